pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer for the 8-bit core's fetch stage. Holds the D-bit PC, sequences it through start, run and halt, and drives the 4-bit address of the branch-target LUT. Each run cycle it computes the next PC from the control inputs: increment, absolute branch via LUT target, PC-relative branch, call or return. Call/return addresses live in a small internal return-address stack.

## Interface
- D, 12, PC and target width
- SD, 4, return-address stack depth (power of two, ≥2)
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high
- Start  in  1  begin execution at PC 0 (sampled in IDLE/HALTED only)
- Stall  in  1  freeze PC, state and stack for this cycle
- BrIdx  in  4  LUT index for absolute branch or call
- BrAbs  in  1  absolute branch request
- BrRel  in  1  relative branch request
- Taken  in  1  branch condition; qualifies BrAbs/BrRel only
- RelOff  in  8  signed relative offset
- Call  in  1  unconditional call to LUT target
- Ret  in  1  return to popped address
- Halt  in  1  stop execution
- LutAddr  out  4  address to branch-target LUT; combinational = BrIdx
- LutTarget  in  D  target returned by LUT, same cycle
- PC  out  D  current program counter (registered)
- Running  out  1  state == RUN
- Done  out  1  state == HALTED
- StackErr  out  1  sticky overflow/underflow flag

## Operation
- States: IDLE, RUN, HALTED. Reset → IDLE, PC=0, stack empty (count 0), StackErr=0, Running=0, Done=0.
- IDLE: PC holds 0. Start=1 → RUN, PC=0. Other inputs ignored.
- RUN, Stall=1: no change to PC, state, stack or StackErr.
- RUN, Stall=0: exactly one action per cycle, in priority order:
  1. Halt → HALTED, PC holds.
  2. Ret: stack non-empty → PC=pop. Empty → StackErr=1, PC=PC+1.
  3. Call: stack not full → push PC+1, PC=LutTarget. Full → StackErr=1, no push, PC=PC+1.
  4. BrAbs & Taken → PC=LutTarget.
  5. BrRel & Taken → PC=PC+sext(RelOff).
  6. Otherwise PC=PC+1. This includes BrAbs/BrRel with Taken=0.
- Arithmetic: all PC sums are modulo 2^D. RelOff is sign-extended to D bits. Wrap in both directions is legal and silent: 4095+1=0, 3+(-5)=4094.
- Pushed return value is (PC+1) mod 2^D.
- Stack is LIFO with SD entries. Pop returns the most recent push. Push and pop never occur in the same cycle (priority guarantees this).
- HALTED: PC holds, Done=1. Start=1 → RUN, PC=0, stack cleared, StackErr cleared. Stall is ignored outside RUN.
- StackErr stays set until Reset or restart from HALTED.
- Reset has priority over every input in every state, including mid-stall and mid-call.

## Timing
- Next PC appears on PC one cycle after the controls are sampled. The fetch stage sees the new address in the following cycle.
- LutAddr→LutTarget is a combinational path within one cycle. No registered LUT.
- Start→RUN: one cycle. Running rises and PC=0 on the same edge.
- Halt sampled → Done=1 on the next edge. The Halt-cycle PC is retained.
- Stall is single-cycle granular and may be held arbitrarily long. Release resumes with the inputs present on that cycle.
- Running, Done and StackErr are registered. No combinational input→output paths except LutAddr.

## Test plan
- Reset then Start, no controls for 5 cycles → PC 0,1,2,3,4,5; Running=1, Done=0.
- At PC=10, BrAbs=1, Taken=1, BrIdx=1, LutTarget=159 → PC=159 next cycle. Same with Taken=0 → PC=11.
- At PC=3, BrRel=1, Taken=1, RelOff=-5 → PC=4094. At PC=4095 with no control → PC=0.
- Nested calls: calls at PCs 20, 177, 181, 185 with targets 177, 181, 185, 191, then 4 Ret → PCs 186, 182, 178, 21. A fifth Call while full → StackErr=1, PC+1. A Ret when empty → StackErr=1.
- Halt and Call both asserted at PC=50 → HALTED, PC=50, no push, Done=1 next cycle. Then Start → PC=0, stack empty, StackErr=0.
- Stall held 3 cycles with BrAbs/Taken asserted at PC=7 → PC stays 7. On release, PC=LutTarget. Reset asserted mid-stall → IDLE, PC=0 next cycle.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control, branch-target LUT and status bundle of the PC sequencer
interface pc_sequencer_if #(
   parameter int D = 12
);
   logic         start;
   logic         stall;
   logic [3:0]   br_idx;
   logic         br_abs;
   logic         br_rel;
   logic         taken;
   logic [7:0]   rel_off;
   logic         call;
   logic         ret;
   logic         halt;
   logic [3:0]   lut_addr;
   logic [D-1:0] lut_target;
   logic [D-1:0] pc;
   logic         running;
   logic         done;
   logic         stack_err;

   modport master (
      output start, stall, br_idx, br_abs, br_rel, taken, rel_off, call, ret, halt, lut_target,
      input  lut_addr, pc, running, done, stack_err
   );

   modport slave (
      input  start, stall, br_idx, br_abs, br_rel, taken, rel_off, call, ret, halt, lut_target,
      output lut_addr, pc, running, done, stack_err
   );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage program counter sequencer with return-address stack
module pc_sequencer #(
   parameter int D  = 12,
   parameter int SD = 4
) (
   input  logic          clk,
   input  logic          rst,
   pc_sequencer_if.slave bus
);
   localparam int PW = $clog2(SD);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_HALTED
   } state_t;

   state_t        state;
   logic [D-1:0]  pc;
   logic [D-1:0]  stack_mem [SD];
   logic [CW-1:0] depth;
   logic          running;
   logic          done;
   logic          stack_err;

   logic [D-1:0]  rel_ext;
   logic [D-1:0]  pc_inc;
   logic [D-1:0]  pc_rel;
   logic [PW-1:0] push_idx;
   logic [PW-1:0] pop_idx;
   logic          stack_empty;
   logic          stack_full;

   assign rel_ext     = {{(D-8){bus.rel_off[7]}}, bus.rel_off};
   assign pc_inc      = pc + D'(1);
   assign pc_rel      = pc + rel_ext;
   // depth is one wider than the index so "full" is distinguishable from "empty"
   assign push_idx    = depth[PW-1:0];
   assign pop_idx     = push_idx - PW'(1);
   assign stack_empty = (depth == '0);
   assign stack_full  = (depth == CW'(SD));

   assign bus.lut_addr  = bus.br_idx;
   assign bus.pc        = pc;
   assign bus.running   = running;
   assign bus.done      = done;
   assign bus.stack_err = stack_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         pc        <= '0;
         depth     <= '0;
         stack_err <= 1'b0;
         running   <= 1'b0;
         done      <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state   <= S_RUN;
                  pc      <= '0;
                  running <= 1'b1;
                  done    <= 1'b0;
               end
            end

            S_RUN: begin
               if (!bus.stall) begin
                  if (bus.halt) begin
                     state   <= S_HALTED;
                     running <= 1'b0;
                     done    <= 1'b1;
                  end else if (bus.ret) begin
                     if (!stack_empty) begin
                        pc    <= stack_mem[pop_idx];
                        depth <= depth - CW'(1);
                     end else begin
                        stack_err <= 1'b1;
                        pc        <= pc_inc;
                     end
                  end else if (bus.call) begin
                     if (!stack_full) begin
                        stack_mem[push_idx] <= pc_inc;
                        depth               <= depth + CW'(1);
                        pc                  <= bus.lut_target;
                     end else begin
                        stack_err <= 1'b1;
                        pc        <= pc_inc;
                     end
                  end else if (bus.br_abs && bus.taken) begin
                     pc <= bus.lut_target;
                  end else if (bus.br_rel && bus.taken) begin
                     pc <= pc_rel;
                  end else begin
                     pc <= pc_inc;
                  end
               end
            end

            S_HALTED: begin
               // restart clears the stack and the sticky error
               if (bus.start) begin
                  state     <= S_RUN;
                  pc        <= '0;
                  depth     <= '0;
                  stack_err <= 1'b0;
                  running   <= 1'b1;
                  done      <= 1'b0;
               end
            end

            default: begin
               state   <= S_IDLE;
               pc      <= '0;
               depth   <= '0;
               running <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed plan plus randomized run against a behavioural model
module tb_pc_sequencer;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pc_sequencer_if #(.D(12)) ifc ();
   logic [11:0] lut [16];
   assign ifc.lut_target = lut[ifc.lut_addr];

   pc_sequencer #(.D(12), .SD(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // model: 0 idle, 1 run, 2 halted; stack as a queue of return addresses
   int m_state;
   int m_pc;
   bit m_err;
   int m_stk[$];

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clr_in();
      rst         = 1'b0;
      ifc.start   = 1'b0;
      ifc.stall   = 1'b0;
      ifc.br_idx  = 4'd0;
      ifc.br_abs  = 1'b0;
      ifc.br_rel  = 1'b0;
      ifc.taken   = 1'b0;
      ifc.rel_off = 8'd0;
      ifc.call    = 1'b0;
      ifc.ret     = 1'b0;
      ifc.halt    = 1'b0;
   endtask

   task automatic model_step();
      int r;
      if (rst) begin
         m_state = 0;
         m_pc    = 0;
         m_err   = 1'b0;
         m_stk.delete();
      end else if (m_state != 1) begin
         if (ifc.start) begin
            if (m_state == 2) begin
               m_stk.delete();
               m_err = 1'b0;
            end
            m_state = 1;
            m_pc    = 0;
         end
      end else if (!ifc.stall) begin
         if (ifc.halt) begin
            m_state = 2;
         end else if (ifc.ret) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin
               m_err = 1'b1;
               m_pc  = (m_pc + 1) & 'hFFF;
            end
         end else if (ifc.call) begin
            if (m_stk.size() < 4) begin
               m_stk.push_back((m_pc + 1) & 'hFFF);
               m_pc = int'(lut[ifc.br_idx]);
            end else begin
               m_err = 1'b1;
               m_pc  = (m_pc + 1) & 'hFFF;
            end
         end else if (ifc.br_abs && ifc.taken) begin
            m_pc = int'(lut[ifc.br_idx]);
         end else if (ifc.br_rel && ifc.taken) begin
            r    = $signed(ifc.rel_off);
            m_pc = (m_pc + r) & 'hFFF;
         end else begin
            m_pc = (m_pc + 1) & 'hFFF;
         end
      end
   endtask

   task automatic cyc();
      #1;
      chk("lut_addr", int'(ifc.lut_addr), int'(ifc.br_idx));
      model_step();
      @(posedge clk);
      #1;
      chk("pc", int'(ifc.pc), m_pc);
      chk("running", int'(ifc.running), int'(m_state == 1));
      chk("done", int'(ifc.done), int'(m_state == 2));
      chk("stack_err", int'(ifc.stack_err), int'(m_err));
   endtask

   task automatic nop();
      clr_in();
      cyc();
   endtask

   task automatic go_abs(input int idx);
      clr_in();
      ifc.br_abs = 1'b1;
      ifc.taken  = 1'b1;
      ifc.br_idx = 4'(idx);
      cyc();
   endtask

   task automatic do_call(input int idx);
      clr_in();
      ifc.call   = 1'b1;
      ifc.br_idx = 4'(idx);
      cyc();
   endtask

   task automatic do_ret();
      clr_in();
      ifc.ret = 1'b1;
      cyc();
   endtask

   initial begin
      for (int i = 0; i < 16; i++) lut[i] = 12'($urandom);
      lut[1]  = 12'd159;
      lut[2]  = 12'd177;
      lut[3]  = 12'd181;
      lut[4]  = 12'd185;
      lut[5]  = 12'd191;
      lut[6]  = 12'd20;
      lut[7]  = 12'd10;
      lut[8]  = 12'd3;
      lut[9]  = 12'd4095;
      lut[10] = 12'd50;
      lut[11] = 12'd7;

      clr_in();
      rst = 1'b1;
      cyc();
      cyc();
      chk("reset_pc", int'(ifc.pc), 0);
      chk("reset_running", int'(ifc.running), 0);

      clr_in();
      ifc.start = 1'b1;
      cyc();
      chk("start_pc", int'(ifc.pc), 0);
      chk("start_running", int'(ifc.running), 1);
      for (int k = 1; k <= 5; k++) begin
         nop();
         chk("inc_pc", int'(ifc.pc), k);
      end

      go_abs(7);
      go_abs(1);
      chk("abs_taken", int'(ifc.pc), 159);
      go_abs(7);
      clr_in();
      ifc.br_abs = 1'b1;
      ifc.br_idx = 4'd1;
      cyc();
      chk("abs_not_taken", int'(ifc.pc), 11);

      go_abs(8);
      clr_in();
      ifc.br_rel  = 1'b1;
      ifc.taken   = 1'b1;
      ifc.rel_off = 8'hFB;
      cyc();
      chk("rel_wrap_down", int'(ifc.pc), 4094);
      go_abs(9);
      nop();
      chk("inc_wrap_up", int'(ifc.pc), 0);

      go_abs(6);
      do_call(2);
      do_call(3);
      do_call(4);
      do_call(5);
      chk("call_nested", int'(ifc.pc), 191);
      do_call(2);
      chk("call_full_pc", int'(ifc.pc), 192);
      chk("call_full_err", int'(ifc.stack_err), 1);
      do_ret();
      chk("ret1", int'(ifc.pc), 186);
      do_ret();
      chk("ret2", int'(ifc.pc), 182);
      do_ret();
      chk("ret3", int'(ifc.pc), 178);
      do_ret();
      chk("ret4", int'(ifc.pc), 21);
      do_ret();
      chk("ret_empty_pc", int'(ifc.pc), 22);

      go_abs(10);
      clr_in();
      ifc.halt   = 1'b1;
      ifc.call   = 1'b1;
      ifc.br_idx = 4'd2;
      cyc();
      chk("halt_pc", int'(ifc.pc), 50);
      chk("halt_done", int'(ifc.done), 1);
      nop();
      chk("halted_hold", int'(ifc.pc), 50);
      clr_in();
      ifc.start = 1'b1;
      cyc();
      chk("restart_err", int'(ifc.stack_err), 0);
      do_ret();
      chk("restart_empty", int'(ifc.stack_err), 1);

      go_abs(11);
      clr_in();
      ifc.stall  = 1'b1;
      ifc.br_abs = 1'b1;
      ifc.taken  = 1'b1;
      ifc.br_idx = 4'd1;
      repeat (3) cyc();
      chk("stall_hold", int'(ifc.pc), 7);
      ifc.stall = 1'b0;
      cyc();
      chk("stall_release", int'(ifc.pc), 159);
      ifc.stall = 1'b1;
      ifc.call  = 1'b1;
      cyc();
      rst = 1'b1;
      cyc();
      chk("stall_reset_pc", int'(ifc.pc), 0);
      chk("stall_reset_running", int'(ifc.running), 0);

      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(7) == 0) lut[$urandom_range(15)] = 12'($urandom);
         rst         = ($urandom_range(63) == 0);
         ifc.start   = ($urandom_range(7) == 0);
         ifc.stall   = ($urandom_range(3) == 0);
         ifc.halt    = ($urandom_range(19) == 0);
         ifc.ret     = ($urandom_range(5) == 0);
         ifc.call    = ($urandom_range(5) == 0);
         ifc.br_abs  = 1'($urandom);
         ifc.br_rel  = 1'($urandom);
         ifc.taken   = 1'($urandom);
         ifc.br_idx  = 4'($urandom);
         ifc.rel_off = 8'($urandom);
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
